// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants and the receive-buffer entry layout.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int CLOCKS_PER_BIT  = 8;
    localparam int RX_SYNC_STAGES  = 3;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_e;

    typedef struct packed {
        logic                       parity_err;
        logic [UART_DATA_WIDTH-1:0] data;
    } rx_entry_t;

    function automatic logic is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with extra-MSB pointers.
module sync_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en;
    logic             rd_en;
    logic             full;
    logic             empty;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign rd_en = pop_i && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO still takes the push.
    assign wr_en = push_i && (!full || rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign valid_o = !empty;
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = full;
    assign empty_o = empty;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: edge-detected push, parity tagging, sticky overflow.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = UART_DATA_WIDTH,
    parameter int  DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_data_valid,
    input  logic                  rx_error,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_parity_err,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow,
    input  logic                  clear_overflow
);

    logic                  valid_q;
    logic                  overflow_q, overflow_d;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic [DATA_WIDTH:0]   wdata;
    logic [DATA_WIDTH:0]   rdata;

    // The receiver may hold data_is_valid for many cycles; only its rising edge counts.
    assign push  = rx_data_valid && !valid_q;
    assign pop   = o_valid && i_ready;
    assign drop  = push && o_full && !pop;
    assign wdata = {rx_error, rx_data};

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (rdata),
        .valid_o (o_valid),
        .count_o (o_count),
        .full_o  (o_full),
        .empty_o (o_empty)
    );

    assign o_data       = rdata[DATA_WIDTH-1:0];
    assign o_parity_err = rdata[DATA_WIDTH];

    always_comb begin
        overflow_d = overflow_q;
        if (drop) overflow_d = 1'b1;
        else if (clear_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= rx_data_valid;
            overflow_q <= overflow_d;
        end
    end

    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with DEPTH = 4.
module tb_uart_rx_fifo;

    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] rx_data = '0;
    logic          rx_data_valid = 1'b0;
    logic          rx_error = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_parity_err;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [2:0]    o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_overflow;
    logic          clear_overflow = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_data_valid  (rx_data_valid),
        .rx_error       (rx_error),
        .o_data         (o_data),
        .o_parity_err   (o_parity_err),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_count        (o_count),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_overflow     (o_overflow),
        .clear_overflow (clear_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle valid pulse, then one idle cycle; returns at a negedge.
    task automatic push_byte(input logic [7:0] d, input logic e);
        rx_data       = d;
        rx_error      = e;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
        rx_error      = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_one(input string tag, input logic [7:0] exp);
        chk(tag, {24'h0, o_data}, {24'h0, exp});
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    initial begin
        // 1: reset state
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_full", 32'(o_full), 32'd0);

        // 2: long valid pulse yields one entry
        rx_data = 8'hA5;
        rx_error = 1'b0;
        rx_data_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk("long_count", 32'(o_count), 32'd1);
        end
        rx_data_valid = 1'b0;
        @(negedge clk);
        chk("long_count_end", 32'(o_count), 32'd1);
        chk("long_perr", 32'(o_parity_err), 32'd0);
        pop_one("long_data", 8'hA5);
        chk("long_empty", 32'(o_empty), 32'd1);

        // 3: parity tag follows the entry
        push_byte(8'h11, 1'b1);
        chk("perr_tag", 32'(o_parity_err), 32'd1);
        pop_one("perr_data", 8'h11);
        chk("perr_empty", 32'(o_empty), 32'd1);
        chk("perr_clr", 32'(o_parity_err), 32'd0);

        // 4: fill, overflow, drain, clear
        for (int i = 1; i <= 4; i++) push_byte(8'(i), 1'b0);
        chk("fill_full", 32'(o_full), 32'd1);
        chk("fill_count", 32'(o_count), 32'd4);
        chk("fill_noovf", 32'(o_overflow), 32'd0);
        push_byte(8'h05, 1'b0);
        chk("ovf_set", 32'(o_overflow), 32'd1);
        chk("ovf_count", 32'(o_count), 32'd4);
        for (int i = 1; i <= 4; i++) pop_one("drain_data", 8'(i));
        chk("drain_empty", 32'(o_empty), 32'd1);
        chk("ovf_sticky", 32'(o_overflow), 32'd1);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        chk("ovf_clear", 32'(o_overflow), 32'd0);

        // 5: push while full with a simultaneous pop
        for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i), 1'b0);
        chk("pp_full", 32'(o_full), 32'd1);
        rx_data = 8'h77;
        rx_data_valid = 1'b1;
        i_ready = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
        i_ready = 1'b0;
        chk("pp_count", 32'(o_count), 32'd4);
        chk("pp_noovf", 32'(o_overflow), 32'd0);
        @(negedge clk);
        chk("pp_noovf2", 32'(o_overflow), 32'd0);
        pop_one("pp_d1", 8'hA1);
        pop_one("pp_d2", 8'hA2);
        pop_one("pp_d3", 8'hA3);
        pop_one("pp_d4", 8'h77);
        chk("pp_empty", 32'(o_empty), 32'd1);

        // 6: pointer wrap, then reset mid-stream
        for (int i = 0; i < 10; i++) begin
            push_byte(8'(i), 1'b0);
            pop_one("wrap_data", 8'(i));
        end
        chk("wrap_empty", 32'(o_empty), 32'd1);
        push_byte(8'h31, 1'b0);
        push_byte(8'h32, 1'b0);
        push_byte(8'h33, 1'b0);
        chk("mid_count", 32'(o_count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("async_count", 32'(o_count), 32'd0);
        chk("async_empty", 32'(o_empty), 32'd1);
        chk("async_data", 32'(o_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_valid", 32'(o_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
